// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM for the multicycle MIPS datapath
//
// Decodes the instruction opcode and steps one instruction through 3-5 states,
// driving the datapath enables and the 2-bit ALUOp for the ALU control decoder.
// Memory states (FETCH, MEMRD, MEMWR) wait on mem_ready and abort to FETCH with a
// mem_err pulse after MEM_TIMEOUT consecutive not-ready cycles.
//
// Optional feature macro: CTRL_ANDI_EN (andi decodes through ADDIEX/ADDIWB with alu_op=11).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   opcode            instr[31:26], sampled in DECODE and MEMADR only
//   zero              ALU zero flag (conditional PC load in BRANCH)
//   mem_ready         memory completes the access this cycle
//   mem_req/mem_write memory request / write strobe
//   iord              address mux select (0=PC, 1=ALUOut)
//   ir_write, pc_en   instruction register load, PC load
//   pc_src            PC source (00=ALU, 01=ALUOut, 10=jump target)
//   alu_src_a/_b      ALU operand selects
//   alu_op            ALUOp to the ALU control decoder
//   reg_write/reg_dst/mem_to_reg  register file write controls
//   mem_err, illegal  one-cycle error pulses
//   state             current state code (debug)

module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mem_err,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_ANDI_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
`endif

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_state;
    logic              timeout;
    logic              pc_write;
    logic              branch;
`ifdef CTRL_ANDI_EN
    // Remembers andi across ADDIEX, where opcode is no longer sampled.
    logic              is_andi_q, is_andi_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
`ifdef CTRL_ANDI_EN
            is_andi_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef CTRL_ANDI_EN
            is_andi_q  <= is_andi_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
`ifdef CTRL_ANDI_EN
        is_andi_d  = is_andi_q;
`endif

        // wait_cnt_q holds the number of earlier consecutive not-ready cycles, so the
        // current not-ready cycle is number wait_cnt_q+1. A ready cycle always wins.
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        timeout   = mem_state && !mem_ready && (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1));
        if (mem_state && !mem_ready && !timeout) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        mem_err = timeout;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef CTRL_ANDI_EN
                    OP_ANDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
`ifdef CTRL_ANDI_EN
                is_andi_d = (opcode == OP_ANDI);
`endif
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready || timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
`ifdef CTRL_ANDI_EN
                alu_op    = is_andi_q ? 2'b11 : 2'b00;
`else
                alu_op    = 2'b00;
`endif
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        pc_en = pc_write | (branch & zero);

        // Outputs are forced low for as long as reset is held, not just at its edge.
        if (!rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            pc_src     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            mem_err    = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for mips_multicycle_control

module tb_mips_multicycle_control;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, mem_err, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .mem_err(mem_err), .illegal(illegal), .state(state)
    );

    logic [20:0] exp_q[$];
    int          force_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [20:0] ev(input int st, input bit rdy, input bit z,
                                       input bit err, input bit ill, input bit andi);
        logic mreq, mw, io, irw, pce, a, rw, rd, m2r;
        logic [1:0] psrc, b, op;
        {mreq, mw, io, irw, pce, a, rw, rd, m2r} = '0;
        psrc = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            0:  begin mreq = 1; b = 2'b01; irw = rdy; pce = rdy; end
            1:  b = 2'b11;
            2:  begin a = 1; b = 2'b10; end
            3:  begin mreq = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; mw = 1; io = 1; end
            6:  begin a = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin a = 1; op = 2'b01; psrc = 2'b01; pce = z; end
            9:  begin a = 1; b = 2'b10; op = andi ? 2'b11 : 2'b00; end
            10: rw = 1;
            11: begin pce = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {mreq, mw, io, irw, pce, psrc, a, b, op, rw, rd, m2r, err, ill, 4'(st)};
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    task automatic cyc(input int st, input bit rdy, input logic [5:0] op,
                       input bit err, input bit ill, input bit andi);
        bit z;
        z = bit'($urandom_range(0, 1));
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        exp_q.push_back(ev(st, rdy, z, err, ill, andi));
    endtask

    task automatic rcyc();
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = bit'($urandom_range(0, 1));
        opcode    = junk();
        zero      = bit'($urandom_range(0, 1));
        exp_q.push_back('0);
    endtask

    function automatic int pick_stall();
        int r;
        if (force_q.size() != 0) return force_q.pop_front();
        r = int'($urandom_range(0, 99));
        if (r < 70) return 0;
        if (r < 90) return int'($urandom_range(1, 4));
        return int'($urandom_range(13, 17));
    endfunction

    task automatic mem_phase(input int st, output bit ok);
        int stall, cnt;
        stall = pick_stall();
        cnt   = 0;
        ok    = 1'b0;
        forever begin
            if (stall == 0) begin
                cyc(st, 1'b1, junk(), 1'b0, 1'b0, 1'b0);
                ok = 1'b1;
                return;
            end
            stall--;
            cnt++;
            if (cnt == TMO) begin
                cyc(st, 1'b0, junk(), 1'b1, 1'b0, 1'b0);
                return;
            end
            cyc(st, 1'b0, junk(), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_instr(input logic [5:0] op);
        bit ok, legal;
        do mem_phase(0, ok); while (!ok);
        case (op)
            6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02: legal = 1'b1;
`ifdef CTRL_ANDI_EN
            6'h0c: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        cyc(1, bit'($urandom_range(0, 1)), op, 1'b0, !legal, 1'b0);
        case (op)
            6'h00: begin cyc(6, 1'b1, junk(), 0, 0, 0); cyc(7, 1'b0, junk(), 0, 0, 0); end
            6'h23: begin
                cyc(2, bit'($urandom_range(0, 1)), op, 0, 0, 0);
                mem_phase(3, ok);
                if (ok) cyc(4, 1'b1, junk(), 0, 0, 0);
            end
            6'h2b: begin
                cyc(2, bit'($urandom_range(0, 1)), op, 0, 0, 0);
                mem_phase(5, ok);
            end
            6'h04: cyc(8, 1'b1, junk(), 0, 0, 0);
            6'h08: begin cyc(9, 1'b0, junk(), 0, 0, 0); cyc(10, 1'b1, junk(), 0, 0, 0); end
            6'h02: cyc(11, 1'b0, junk(), 0, 0, 0);
            6'h0c: begin
`ifdef CTRL_ANDI_EN
                cyc(9, 1'b0, junk(), 0, 0, 1); cyc(10, 1'b1, junk(), 0, 0, 0);
`endif
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [20:0] e, g;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = {mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, mem_err, illegal, state};
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL ctrl_outputs t=%0t: got %b expected %b (mreq,mw,iord,irw,pcen,psrc,a,b,aluop,rw,rd,m2r,err,ill,state)",
                             $time, g, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops[8];
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h0c, 6'h3f};

        rcyc(); rcyc();
        @(posedge clk); #1 rst = 1'b1;

        cyc(0, 1'b1, junk(), 0, 0, 0);
        cyc(1, 1'b0, 6'h23, 0, 0, 0);
        cyc(2, 1'b1, 6'h23, 0, 0, 0);
        cyc(3, 1'b0, junk(), 0, 0, 0);
        cyc(3, 1'b0, junk(), 0, 0, 0);
        rcyc(); rcyc();
        #2;
        n_tests++;
        if (state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state t=%0t: got %0d expected 0", $time, state);
        end
        n_tests++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_req t=%0t: got %b expected 0", $time, mem_req);
        end
        n_tests++;
        if (ir_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ir_write t=%0t: got %b expected 0", $time, ir_write);
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL release_fetch t=%0t: state=%0d mem_req=%b expected 0/1",
                     $time, state, mem_req);
        end

        force_q = '{15, 0};    run_instr(6'h00);
        force_q = '{14};       run_instr(6'h00);
        force_q = '{0, 3};     run_instr(6'h23);
        force_q = '{0, 15};    run_instr(6'h2b);
        force_q = '{0, 15};    run_instr(6'h23);
        force_q = '{0, 0};     run_instr(6'h23);
        force_q = '{0, 0};     run_instr(6'h2b);
        force_q = '{0};        run_instr(6'h04);
        force_q = '{0};        run_instr(6'h04);
        force_q = '{0};        run_instr(6'h08);
        force_q = '{0};        run_instr(6'h0c);
        force_q = '{0};        run_instr(6'h02);
        force_q = '{0};        run_instr(6'h3f);

        for (int i = 0; i < 300; i++) begin
            int k;
            k = int'($urandom_range(0, 8));
            run_instr(k == 8 ? junk() : ops[k]);
        end

        repeat (3) @(negedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
